// File: rtl/shift_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_sched_pkg
// Brief    : Shared types and constants for the shifter scheduler.
// Revision : 1.0
// ============================================================================
package shift_sched_pkg;

  localparam int W_DEF  = 4;
  localparam int CW_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CAPT  = 2'd2
  } state_e;

  localparam logic OWN0 = 1'b0;
  localparam logic OWN1 = 1'b1;

endpackage : shift_sched_pkg
`default_nettype wire

// File: rtl/shift_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_sched_if
// Brief    : Client-side request/grant/done bundle of the shifter scheduler.
// Revision : 1.0
// ============================================================================
interface shift_sched_if #(
  parameter int W  = 4,
  parameter int CW = 4
);

  logic          req0;
  logic          req1;
  logic [W-1:0]  data0;
  logic [W-1:0]  data1;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;
  logic          gnt0;
  logic          gnt1;
  logic          done0;
  logic          done1;
  logic [W-1:0]  res;

  modport master (
    output req0, req1, data0, data1, cnt0, cnt1,
    input  gnt0, gnt1, done0, done1, res
  );

  modport slave (
    input  req0, req1, data0, data1, cnt0, cnt1,
    output gnt0, gnt1, done0, done1, res
  );

endinterface : shift_sched_if
`default_nettype wire

// File: rtl/shift_sched_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-input arbiter; round-robin when SHIFT_SCHED_RR_EN is defined,
//            fixed priority to input 0 otherwise.
// Revision : 1.0
// ============================================================================
module rr_arb2
  import shift_sched_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [1:0] req_i,
  input  wire logic       adv_i,
  output logic      [1:0] gnt_o
);

`ifdef SHIFT_SCHED_RR_EN
  logic ptr_q;
  logic ptr_d;

  // ptr_q names the client that wins a tie next.
  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11) begin
      gnt_o = (ptr_q == OWN0) ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = gnt_o[0] ? OWN1 : OWN0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= OWN0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst, adv_i};

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0]) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
  end
`endif

endmodule : rr_arb2
`default_nettype wire

// File: rtl/shift_sched.sv
`default_nettype none
// ============================================================================
// Module   : shift_sched
// Brief    : Two-client scheduler/sequencer for the shared 4-bit shifter.
//            Arbitration mode selected by macro SHIFT_SCHED_RR_EN.
// Revision : 1.0
// ============================================================================
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  wire logic         clk,
  input  wire logic         rst,
  shift_sched_if.slave      bus,
  output logic              busy_o,
  output logic [W-1:0]      si_o,
  output logic              shn_o,
  input  wire logic [W-1:0] so_i
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_SHIFT = ST_SHIFT;
  localparam logic [1:0] S_CAPT  = ST_CAPT;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic [W-1:0]  si_q, si_d;
  logic          shn_q, shn_d;
  logic [W-1:0]  res_q, res_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic [1:0]    win;
  logic          adv;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i ({bus.req1, bus.req0}),
    .adv_i (adv),
    .gnt_o (win)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    si_d    = si_q;
    shn_d   = shn_q;
    res_d   = res_q;
    gnt_d   = 2'b00;
    done_d  = 2'b00;
    adv     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win != 2'b00) begin
          adv   = 1'b1;
          gnt_d = win;
          if (win[0]) begin
            owner_d = OWN0;
            si_d    = bus.data0;
            cnt_d   = bus.cnt0;
          end else begin
            owner_d = OWN1;
            si_d    = bus.data1;
            cnt_d   = bus.cnt1;
          end
          // A zero count skips SHIFT entirely.
          if (cnt_d != '0) begin
            state_d = S_SHIFT;
            shn_d   = 1'b1;
          end else begin
            state_d = S_CAPT;
            shn_d   = 1'b0;
          end
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_CAPT;
          shn_d   = 1'b0;
        end
      end
      S_CAPT: begin
        res_d   = so_i;
        done_d  = (owner_q == OWN1) ? 2'b10 : 2'b01;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        shn_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      owner_q <= OWN0;
      si_q    <= '0;
      shn_q   <= 1'b0;
      res_q   <= '0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      si_q    <= si_d;
      shn_q   <= shn_d;
      res_q   <= res_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign si_o      = si_q;
  assign shn_o     = shn_q;
  assign bus.gnt0  = gnt_q[0];
  assign bus.gnt1  = gnt_q[1];
  assign bus.done0 = done_q[0];
  assign bus.done1 = done_q[1];
  assign bus.res   = res_q;

endmodule : shift_sched
`default_nettype wire
